key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_if.sv | 31 +++
 rtl/key_debounce.sv | 172 +++++++++++++++++
 tb/tb_key_debounce.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// Key debouncer bus: raw active-low keys in, debounced levels and event pulses out.
// The slave side is the debouncer; the master side drives the keys and consumes events.
interface key_debounce_if;
    logic [3:0] key_n;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_repeat;
    logic       key_valid;
    logic [1:0] key_code;

    modport master (
        output key_n,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_repeat,
        input  key_valid,
        input  key_code
    );

    modport slave (
        input  key_n,
        output key_state,
        output key_press,
        output key_release,
        output key_repeat,
        output key_valid,
        output key_code
    );
endinterface

// File: rtl/key_debounce.sv
// Four-key debouncer with press/release pulses and optional auto-repeat.
// Define KEY_REPEAT_EN to build the per-key hold/repeat FSMs; otherwise key_repeat is 0.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 20000000
) (
    input  logic          clk,
    input  logic          rst,
    key_debounce_if.slave kb
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'd1048575) begin : g_bad_db
        $error("DEBOUNCE_CYCLES out of range");
    end
    if (HOLD_CYCLES < 2 || HOLD_CYCLES > 32'd134217727) begin : g_bad_hold
        $error("HOLD_CYCLES out of range");
    end
    if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 32'd134217727) begin : g_bad_rep
        $error("REPEAT_CYCLES out of range");
    end

    localparam logic [19:0] LP_DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [3:0]  r_state;
    logic [3:0]  r_state_d;
    logic [3:0]  r_press;
    logic [3:0]  r_release;
    logic [19:0] r_cnt [4];
    logic [3:0]  w_sample;
    logic [3:0]  w_rise;
    logic [3:0]  w_repeat;
    logic [3:0]  w_evt;
    logic [1:0]  w_code;

    assign w_sample = ~r_sync2;
    assign w_rise   = r_state & ~r_state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= kb.key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Counter tracks consecutive disagreeing samples; any agreement restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_sample[i] == r_state[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LP_DB_LAST) begin
                    r_cnt[i]   <= '0;
                    r_state[i] <= ~r_state[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 20'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_d <= '0;
            r_press   <= '0;
            r_release <= '0;
        end else begin
            r_state_d <= r_state;
            r_press   <= r_state & ~r_state_d;
            r_release <= ~r_state & r_state_d;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam logic [26:0] LP_HOLD_LAST = 27'(HOLD_CYCLES - 1);
    localparam logic [26:0] LP_REP_LAST  = 27'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } rep_st_t;

    rep_st_t     r_st  [4];
    logic [26:0] r_tmr [4];
    logic [3:0]  r_repeat;

    // HOLD is entered on the same edge that registers key_press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_repeat <= '0;
            for (int i = 0; i < 4; i++) begin
                r_st[i]  <= ST_IDLE;
                r_tmr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_repeat[i] <= 1'b0;
                if (!r_state[i]) begin
                    r_st[i]  <= ST_IDLE;
                    r_tmr[i] <= '0;
                end else begin
                    unique case (r_st[i])
                        ST_IDLE: begin
                            if (w_rise[i]) begin
                                r_st[i]  <= ST_HOLD;
                                r_tmr[i] <= '0;
                            end
                        end
                        ST_HOLD: begin
                            if (r_tmr[i] == LP_HOLD_LAST) begin
                                r_st[i]     <= ST_REPEAT;
                                r_tmr[i]    <= '0;
                                r_repeat[i] <= 1'b1;
                            end else begin
                                r_tmr[i] <= r_tmr[i] + 27'd1;
                            end
                        end
                        ST_REPEAT: begin
                            if (r_tmr[i] == LP_REP_LAST) begin
                                r_tmr[i]    <= '0;
                                r_repeat[i] <= 1'b1;
                            end else begin
                                r_tmr[i] <= r_tmr[i] + 27'd1;
                            end
                        end
                        default: begin
                            r_st[i]  <= ST_IDLE;
                            r_tmr[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign w_repeat = r_repeat;
`else
    assign w_repeat = '0;
`endif

    assign w_evt = r_press | w_repeat;

    always_comb begin
        w_code = 2'd0;
        priority case (1'b1)
            w_evt[0]: w_code = 2'd0;
            w_evt[1]: w_code = 2'd1;
            w_evt[2]: w_code = 2'd2;
            w_evt[3]: w_code = 2'd3;
            default:  w_code = 2'd0;
        endcase
    end

    assign kb.key_state   = r_state;
    assign kb.key_press   = r_press;
    assign kb.key_release = r_release;
    assign kb.key_repeat  = w_repeat;
    assign kb.key_valid   = |w_evt;
    assign kb.key_code    = w_code;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE=8, HOLD=40, REPEAT=16.
// Edge numbers count posedges after key_n (or rst) changes on a negedge.
module tb_key_debounce;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

`ifdef KEY_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    key_debounce_if kb ();

    key_debounce #(
        .DEBOUNCE_CYCLES(8),
        .HOLD_CYCLES(40),
        .REPEAT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kb(kb)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] lowest(input logic [3:0] v);
        logic [1:0] c;
        c = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) c = 2'(i);
        end
        return c;
    endfunction

    task automatic chk(input string tag, input int e,
                       input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s edge %0d: observed %b expected %b", tag, e, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int e,
                             input logic [3:0] st, input logic [3:0] pr,
                             input logic [3:0] rl, input logic [3:0] rp);
        logic [3:0] evt;
        evt = pr | rp;
        chk({tag, ".state"},   e, kb.key_state,   st);
        chk({tag, ".press"},   e, kb.key_press,   pr);
        chk({tag, ".release"}, e, kb.key_release, rl);
        chk({tag, ".repeat"},  e, kb.key_repeat,  rp);
        chk({tag, ".valid"},   e, {3'b000, kb.key_valid}, {3'b000, |evt});
        chk({tag, ".code"},    e, {2'b00, kb.key_code},   {2'b00, lowest(evt)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic glitch(input string tag, input int len, input bit acc);
        logic [3:0] st, pr, rl;
        @(negedge clk);
        kb.key_n = 4'b1101;
        for (int e = 1; e <= 24; e++) begin
            tick();
            st = (acc && e >= 10 && e <= 17) ? 4'b0010 : 4'b0000;
            pr = (acc && e == 11) ? 4'b0010 : 4'b0000;
            rl = (acc && e == 19) ? 4'b0010 : 4'b0000;
            check_all(tag, e, st, pr, rl, 4'b0000);
            if (e == len) begin
                @(negedge clk);
                kb.key_n = 4'b1111;
            end
        end
    endtask

    initial begin
        logic [3:0] st, pr, rl, rp;
        rst      = 1'b1;
        kb.key_n = 4'b1111;
        repeat (3) tick();
        check_all("reset", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) tick();
        check_all("idle", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Single press on key 0, then release.
        @(negedge clk);
        kb.key_n = 4'b1110;
        for (int e = 1; e <= 30; e++) begin
            tick();
            st = (e >= 10) ? 4'b0001 : 4'b0000;
            pr = (e == 11) ? 4'b0001 : 4'b0000;
            check_all("press0", e, st, pr, 4'b0000, 4'b0000);
        end
        @(negedge clk);
        kb.key_n = 4'b1111;
        for (int e = 1; e <= 14; e++) begin
            tick();
            st = (e < 10) ? 4'b0001 : 4'b0000;
            rl = (e == 11) ? 4'b0001 : 4'b0000;
            check_all("rel0", e, st, 4'b0000, rl, 4'b0000);
        end

        glitch("glitch5", 5, 1'b0);
        glitch("glitch7", 7, 1'b0);
        glitch("pulse8", 8, 1'b1);

        // Key 2 held 100 cycles: press, hold, repeats, release.
        @(negedge clk);
        kb.key_n = 4'b1011;
        for (int e = 1; e <= 130; e++) begin
            tick();
            st = (e >= 10 && e < 110) ? 4'b0100 : 4'b0000;
            pr = (e == 11) ? 4'b0100 : 4'b0000;
            rl = (e == 111) ? 4'b0100 : 4'b0000;
            rp = (REP && e >= 51 && e < 110 && ((e - 51) % 16) == 0)
                 ? 4'b0100 : 4'b0000;
            check_all("hold2", e, st, pr, rl, rp);
            if (e == 100) begin
                @(negedge clk);
                kb.key_n = 4'b1111;
            end
        end

        // Keys 1 and 3 together.
        @(negedge clk);
        kb.key_n = 4'b0101;
        for (int e = 1; e <= 15; e++) begin
            tick();
            st = (e >= 10) ? 4'b1010 : 4'b0000;
            pr = (e == 11) ? 4'b1010 : 4'b0000;
            check_all("dual", e, st, pr, 4'b0000, 4'b0000);
        end
        @(negedge clk);
        kb.key_n = 4'b1111;
        for (int e = 1; e <= 14; e++) begin
            tick();
            st = (e < 10) ? 4'b1010 : 4'b0000;
            rl = (e == 11) ? 4'b1010 : 4'b0000;
            check_all("dualrel", e, st, 4'b0000, rl, 4'b0000);
        end

        // Reset while key 0 is held and its hold timer is running.
        @(negedge clk);
        kb.key_n = 4'b1110;
        for (int e = 1; e <= 20; e++) begin
            tick();
            st = (e >= 10) ? 4'b0001 : 4'b0000;
            pr = (e == 11) ? 4'b0001 : 4'b0000;
            check_all("prerst", e, st, pr, 4'b0000, 4'b0000);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("inrst", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int e = 1; e <= 3; e++) begin
            tick();
            check_all("inrst", e, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            st = (e >= 10) ? 4'b0001 : 4'b0000;
            pr = (e == 11) ? 4'b0001 : 4'b0000;
            rp = (REP && e == 51) ? 4'b0001 : 4'b0000;
            check_all("postrst", e, st, pr, 4'b0000, rp);
        end
        @(negedge clk);
        kb.key_n = 4'b1111;
        repeat (14) tick();
        check_all("final", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
